// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared definitions for the RV32M multiply/divide execute unit:
//   operand width, iteration count, funct3 encodings, FSM state encoding,
//   special-case result constants and small decode helpers.
//   No ports; imported by muldiv_unit_if, muldiv_datapath and muldiv_unit.

package muldiv_unit_pkg;

    // Operand/result width. Only 32 is supported.
    localparam int XLEN  = 32;
    // One shift-add / shift-subtract step per RUN cycle.
    localparam int ITERS = XLEN;
    localparam int CNT_W = $clog2(ITERS);

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Quotient returned on divide-by-zero, and the most negative integer
    // (dividend of the signed-overflow case and its DIV result).
    localparam logic [XLEN-1:0] DIV0_QUOT = '1;
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // funct3[2] selects the divide family.
    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is a signed operand for everything except the unsigned ops.
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return !((f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU));
    endfunction

    // rs2 is signed only for MUL, MULH, DIV and REM (MULHSU treats it unsigned).
    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Two's-complement magnitude of a value whose effective sign is neg.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Request/writeback bundle between the issue side (register file reads,
//   decoder) and the multiply/divide unit.
//
//   Handshake: Start is a request that the unit accepts on a rising edge
//   where Busy=0; the operands, Funct3 and Rd are captured on that edge and
//   may change freely afterwards. While Busy=1 any Start is dropped (no
//   queueing). Done is a one-cycle completion pulse with no back-pressure:
//   WriteReg/WriteData are valid while Done=1 and RegWrite = Done & (Rd!=0)
//   drives the register file write enable directly.
//
//   master modport : the issuing side (drives request, observes results)
//   slave  modport : muldiv_unit
//   dbg_state      : current FSM state, for observation only

interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] Rs1Data;
    logic [XLEN-1:0] Rs2Data;
    logic [4:0]      Rd;

    logic            Busy;
    logic            Done;
    logic [4:0]      WriteReg;
    logic [XLEN-1:0] WriteData;
    logic            RegWrite;

    state_t          dbg_state;

    modport master (
        output Start, Funct3, Rs1Data, Rs2Data, Rd,
        input  Busy, Done, WriteReg, WriteData, RegWrite, dbg_state
    );

    modport slave (
        input  Start, Funct3, Rs1Data, Rs2Data, Rd,
        output Busy, Done, WriteReg, WriteData, RegWrite, dbg_state
    );

endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath
//   64-bit accumulator/remainder register plus one shift-add (multiply) or
//   restoring shift-subtract (divide) step per enabled cycle, operating on
//   unsigned magnitudes. Sign handling and special cases live in the parent.
//
//   Ports:
//     Clk, Reset : clock, asynchronous active-high reset
//     load       : capture a_mag/b_mag/is_div and initialise the accumulator
//     step       : perform one iteration
//     is_div     : 1 = divide, 0 = multiply (sampled with load)
//     a_mag      : multiplier / dividend magnitude
//     b_mag      : multiplicand / divisor magnitude
//     acc        : multiply -> {product_hi, product_lo}
//                  divide   -> {remainder, quotient}

module muldiv_datapath
    import muldiv_unit_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd_q;
    logic              div_q;

    // Multiply: low half starts as the multiplier and is consumed LSB first;
    // the add carry is kept by shifting the 33-bit sum into the top.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    // Divide: low half starts as the dividend and fills with quotient bits.
    // The shifted partial remainder needs one extra bit before the trial
    // subtract; the subtract result itself always fits back into XLEN bits.
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        rem_sh = acc_q[2*XLEN-1:XLEN-1];
        diff   = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (!diff[XLEN+1]) begin
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        acc_next = div_q ? div_next : mul_next;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else if (load) begin
            acc_q  <= {{XLEN{1'b0}}, a_mag};
            opnd_q <= b_mag;
            div_q  <= is_div;
        end else if (step) begin
            acc_q  <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide execute unit. Accepts one operation at a
//   time, runs ITERS datapath iterations, then applies sign fixup and the
//   divide special cases and issues a single-cycle registered writeback.
//   Latency from the accepting edge to the Done edge is ITERS+1 for every op.
//
//   Ports:
//     Clk   : rising-edge clock
//     Reset : asynchronous active-high reset; aborts any operation in flight
//     bus   : muldiv_unit_if.slave (request inputs, writeback outputs,
//             dbg_state)

module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    muldiv_unit_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load, step;

    // Operation context captured at acceptance
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              sa_q;        // effective sign of rs1
    logic              sb_q;        // effective sign of rs2
    logic              div_zero_q;
    logic              ovf_q;       // INT_MIN / -1 on a signed divide op
    logic [XLEN-1:0]   a_raw_q;     // rs1 as given, returned by REM/REMU by zero

    // Registered outputs
    logic              busy_q, done_q, reg_write_q;
    logic [4:0]        write_reg_q;
    logic [XLEN-1:0]   write_data_q;

    logic [2*XLEN-1:0] acc;
    logic              start_sa, start_sb;
    logic [XLEN-1:0]   start_a_mag, start_b_mag;

    always_comb begin
        start_sa    = rs1_is_signed(bus.Funct3) & bus.Rs1Data[XLEN-1];
        start_sb    = rs2_is_signed(bus.Funct3) & bus.Rs2Data[XLEN-1];
        start_a_mag = magnitude(bus.Rs1Data, start_sa);
        start_b_mag = magnitude(bus.Rs2Data, start_sb);
    end

    muldiv_datapath u_datapath (
        .Clk    (Clk),
        .Reset  (Reset),
        .load   (load),
        .step   (step),
        .is_div (op_is_div(bus.Funct3)),
        .a_mag  (start_a_mag),
        .b_mag  (start_b_mag),
        .acc    (acc)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- Result fixup ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result;

    always_comb begin
        // Signs of unsigned operands were forced to 0 at capture, so these
        // fixups are no-ops for the unsigned ops.
        prod_fix = (sa_q ^ sb_q) ? (~acc + 1'b1) : acc;
        quot_fix = (sa_q ^ sb_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fix  = sa_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

        case (f3_q)
            F3_MUL:                    result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:                  result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU: begin
                if (div_zero_q)        result = DIV0_QUOT;
                else if (ovf_q)        result = INT_MIN;
                else                   result = quot_fix;
            end
            default: begin             // REM, REMU
                if (div_zero_q)        result = a_raw_q;
                else if (ovf_q)        result = '0;
                else                   result = rem_fix;
            end
        endcase
    end

    // ---------------- Context capture ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            f3_q       <= '0;
            rd_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            a_raw_q    <= '0;
        end else if (load) begin
            f3_q       <= bus.Funct3;
            rd_q       <= bus.Rd;
            sa_q       <= start_sa;
            sb_q       <= start_sb;
            div_zero_q <= (bus.Rs2Data == '0);
            ovf_q      <= ((bus.Funct3 == F3_DIV) || (bus.Funct3 == F3_REM)) &&
                          (bus.Rs1Data == INT_MIN) && (bus.Rs2Data == '1);
            a_raw_q    <= bus.Rs1Data;
        end
    end

    // ---------------- Registered outputs ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            if (load) begin
                busy_q <= 1'b1;
            end
            if (state_q == S_FIN) begin
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                reg_write_q  <= (rd_q != 5'd0);
                write_reg_q  <= rd_q;
                write_data_q <= result;
            end
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.RegWrite  = reg_write_q;
    assign bus.WriteReg  = write_reg_q;
    assign bus.WriteData = write_data_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed bench for muldiv_unit: a cycle-level reference model built from
//   plain 64-bit arithmetic and a fixed completion latency, a per-cycle
//   compare process, and directed operations with hand-computed results.

module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int LAT = ITERS + 1;   // edges from acceptance to Done

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endfunction

    // Result of an RV32M op, straight from the architectural definition.
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 0;
        case (f3)
            3'b000: r = sa * sb;
            3'b001: r = (sa * sb) >>> 32;
            3'b010: r = (sa * ub) >>> 32;
            3'b011: begin
                p = {32'd0, a} * {32'd0, b};
                r = longint'(p >> 32);
            end
            3'b100: begin
                if (b == 0) r = -1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = sa;
                else r = sa / sb;
            end
            3'b101: r = (b == 0) ? longint'(32'hFFFF_FFFF) : ua / ub;
            3'b110: begin
                if (b == 0) r = sa;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = sa % sb;
            end
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return 32'(r);
    endfunction

    // ---------------- Reference model ----------------
    logic        m_busy = 1'b0, m_done = 1'b0, m_rw = 1'b0;
    logic [4:0]  m_wreg = '0, m_rd = '0;
    logic [31:0] m_wdata = '0, m_res = '0;
    int          m_left = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_rw = 1'b0;
            m_wreg = '0;   m_wdata = '0;  m_left = 0;
        end else begin
            m_done = 1'b0;
            m_rw   = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_wdata = m_res;
                    m_wreg  = m_rd;
                    m_rw    = (m_rd != 5'd0);
                end
            end else if (bus.Start) begin
                m_busy = 1'b1;
                m_left = LAT;
                m_res  = ref_result(bus.Funct3, bus.Rs1Data, bus.Rs2Data);
                m_rd   = bus.Rd;
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge Clk) begin
        check("cyc_busy",     32'(bus.Busy),      32'(m_busy));
        check("cyc_done",     32'(bus.Done),      32'(m_done));
        check("cyc_regwrite", 32'(bus.RegWrite),  32'(m_rw));
        check("cyc_writereg", 32'(bus.WriteReg),  32'(m_wreg));
        check("cyc_writedata", bus.WriteData,     m_wdata);
    end

    // ---------------- Driver tasks ----------------
    // Leaves Start high across exactly one rising edge, then scrambles the
    // request inputs to show they were captured at acceptance.
    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input bit immediate);
        if (!immediate) @(negedge Clk);
        #1;
        bus.Start   = 1'b1;
        bus.Funct3  = f3;
        bus.Rs1Data = a;
        bus.Rs2Data = b;
        bus.Rd      = rd;
        @(negedge Clk);
        #1;
        bus.Start   = 1'b0;
        bus.Funct3  = 3'($urandom_range(0, 7));
        bus.Rs1Data = $urandom;
        bus.Rs2Data = $urandom;
        bus.Rd      = 5'($urandom_range(0, 31));
    endtask

    // Issues one op, waits (bounded) for Done and checks latency, result and
    // writeback against hand-computed values. inject_at>0 raises a second,
    // different Start that many negedges into the op. Returns at the negedge
    // where Done is high, so a following immediate start lands in that cycle.
    task automatic do_op(input string name, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input bit immediate, input int inject_at);
        int k;
        bit seen, busy_ok;
        drive_start(f3, a, b, rd, immediate);
        k = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && k < 60) begin
            @(negedge Clk);
            k++;
            if (bus.Done) begin
                seen = 1'b1;
            end else begin
                if (!bus.Busy) busy_ok = 1'b0;
                if (inject_at > 0 && k == inject_at) begin
                    #1;
                    bus.Start = 1'b1; bus.Funct3 = 3'b000;
                    bus.Rs1Data = 32'd1000; bus.Rs2Data = 32'd1000; bus.Rd = 5'd9;
                end else if (inject_at > 0 && k == inject_at + 1) begin
                    #1;
                    bus.Start = 1'b0;
                end
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_latency"}, 32'(k - 1), 32'd33);
            check({name, "_data"}, bus.WriteData, exp);
            check({name, "_reg"}, 32'(bus.WriteReg), 32'(rd));
            check({name, "_regwrite"}, 32'(bus.RegWrite), (rd != 0) ? 32'd1 : 32'd0);
            check({name, "_busy_low_at_done"}, 32'(bus.Busy), 32'd0);
            check({name, "_busy_held"}, 32'(busy_ok), 32'd1);
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (bus.Done) n++;
        end
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int n;
        bus.Start = 1'b0; bus.Funct3 = '0; bus.Rs1Data = '0; bus.Rs2Data = '0; bus.Rd = '0;
        #1 Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_busy",      32'(bus.Busy),      32'd0);
        check("rst_done",      32'(bus.Done),      32'd0);
        check("rst_regwrite",  32'(bus.RegWrite),  32'd0);
        check("rst_writereg",  32'(bus.WriteReg),  32'd0);
        check("rst_writedata", bus.WriteData,      32'd0);
        check("rst_state",     32'(bus.dbg_state), 32'(S_IDLE));
        #1 Reset = 1'b0;

        do_op("mul_123x456", F3_MUL, 32'd123, 32'd456, 5'd5, 32'h0000_DB18, 0, 0);

        do_op("mulh_m1m1",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 0, 0);
        do_op("mulhu_m1m1",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0, 0);
        do_op("mulhsu_m1m1", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 0, 0);
        do_op("mul_m1m1",    F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 0, 0);

        do_op("div_789_m7",  F3_DIV,  32'd789, 32'hFFFF_FFF9, 5'd6, 32'hFFFF_FF90, 0, 0);
        do_op("rem_789_m7",  F3_REM,  32'd789, 32'hFFFF_FFF9, 5'd7, 32'h0000_0005, 0, 0);
        do_op("divu_789_m7", F3_DIVU, 32'd789, 32'hFFFF_FFF9, 5'd8, 32'h0000_0000, 0, 0);
        do_op("remu_789_m7", F3_REMU, 32'd789, 32'hFFFF_FFF9, 5'd9, 32'h0000_0315, 0, 0);

        do_op("divu_by0",  F3_DIVU, 32'd456, 32'd0, 5'd10, 32'hFFFF_FFFF, 0, 0);
        do_op("remu_by0",  F3_REMU, 32'd456, 32'd0, 5'd11, 32'h0000_01C8, 0, 0);
        do_op("div_by0",   F3_DIV,  32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFF, 0, 0);
        do_op("rem_by0",   F3_REM,  32'h8000_0000, 32'd0, 5'd13, 32'h8000_0000, 0, 0);
        do_op("div_ovf",   F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0, 0);
        do_op("rem_ovf",   F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 0, 0);

        do_op("div_m100_7", F3_DIV, 32'hFFFF_FF9C, 32'd7, 5'd16, 32'hFFFF_FFF2, 0, 0);
        do_op("rem_m100_7", F3_REM, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFFE, 0, 0);
        do_op("mulh_big",   F3_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd18, 32'h3FFF_FFFF, 0, 0);

        do_op("mul_rd0", F3_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 0, 0);

        // Back-to-back: each start lands in the previous op's Done cycle.
        do_op("b2b_mulhu", F3_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd20, 32'h0000_0001, 0, 0);
        do_op("b2b_divu",  F3_DIVU,  32'd100, 32'd7, 5'd21, 32'd14, 1, 0);
        do_op("b2b_remu",  F3_REMU,  32'd100, 32'd7, 5'd22, 32'd2,  1, 0);

        // Start while busy must be dropped: one Done with the first result.
        do_op("ignored_start", F3_MUL, 32'd7, 32'd9, 5'd23, 32'd63, 0, 6);
        count_done(40, n);
        check("ignored_start_no_extra_done", 32'(n), 32'd0);

        // Reset 10 cycles into a divide aborts it with no Done afterwards.
        drive_start(F3_DIV, 32'd1000, 32'd3, 5'd24, 0);
        repeat (10) @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        check("midrst_busy",      32'(bus.Busy),     32'd0);
        check("midrst_done",      32'(bus.Done),     32'd0);
        check("midrst_regwrite",  32'(bus.RegWrite), 32'd0);
        check("midrst_writedata", bus.WriteData,     32'd0);
        @(negedge Clk);
        #1 Reset = 1'b0;
        count_done(40, n);
        check("midrst_no_done", 32'(n), 32'd0);
        do_op("mul_after_rst", F3_MUL, 32'd2, 32'd3, 5'd25, 32'd6, 0, 0);

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execute unit that sits directly downstream of the register file.
- Consumes the two register-file read operands plus the decoded funct3 and destination register.
- Produces a single-cycle writeback (WriteReg/WriteData/RegWrite) that drives the register file write port.
- Non-pipelined: accepts one operation at a time and holds Busy while it computes.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITERS, XLEN, number of shift-add / shift-subtract iteration cycles.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
Funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Rs1Data  input  XLEN  operand A (register file ReadData1)
Rs2Data  input  XLEN  operand B (register file ReadData2)
Rd  input  5  destination register index
Busy  output  1  high from the acceptance edge until Done is asserted
Done  output  1  one-cycle completion pulse
WriteReg  output  5  writeback index, valid while Done=1
WriteData  output  XLEN  writeback result, valid while Done=1
RegWrite  output  1  writeback enable = Done AND (Rd != 0)

Behaviour:
- Reset (async, active-high): state IDLE; Busy, Done, RegWrite = 0; WriteReg = 0; WriteData = 0; iteration counter = 0.
- All outputs are registered.
- States and transitions:
  - IDLE: Start=1 at edge N latches Funct3, Rd, and operand magnitudes/signs; go to RUN; Busy=1 after edge N.
  - RUN: one iteration per edge; counter runs 0..ITERS-1; after ITERS edges go to FIN.
  - FIN: apply sign fixup / special cases; go to IDLE. At edge N+ITERS+1 Done=1, Busy=0, WriteReg, WriteData and RegWrite load.
  - Done/RegWrite drop on the next edge; WriteData/WriteReg hold their last value.
- Latency: Done is high during the cycle after edge N+33 for XLEN=32, i.e. 33 edges after acceptance. Latency is fixed for every op, including special cases.
- Start while Busy=1 is ignored; no queueing. Start in the same cycle Done=1 is accepted (state is IDLE).
- Operands and Funct3 are captured at acceptance; later input changes have no effect.
- Multiply:
  - Unsigned 32x32 shift-add on magnitudes, 64-bit product.
  - Negate the product if the result sign is 1. MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b) (signed ops only); remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- Rd=0: Done pulses normally, RegWrite stays 0.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the result is discarded and no Done is issued.

Decomposition:
- Shared package:
  - Funct3 encodings (MUL..REMU)
  - XLEN
  - State encoding (IDLE/RUN/FIN)
  - Constants DIV0_QUOT=all-ones and INT_MIN=0x80000000
- One natural sub-module: muldiv_datapath. It holds the 64-bit accumulator/remainder and the shift-add/subtract step, controlled by the FSM in muldiv_unit.

Test Plan:
- MUL 123 x 456, Rd=5 -> 33 edges after Start: Done=1, RegWrite=1, WriteReg=5, WriteData=0x0000DB18 for exactly one cycle; Busy=1 throughout.
- rs1=rs2=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHU -> 0xFFFFFFFE
  - MULHSU -> 0xFFFFFFFF
  - MUL -> 0x00000001
- rs1=789, rs2=-7 (0xFFFFFFF9):
  - DIV -> 0xFFFFFF90 (-112)
  - REM -> 0x00000005
  - DIVU -> 0x00000000
  - REMU -> 0x00000315
- Special cases:
  - DIVU 456/0 -> 0xFFFFFFFF
  - REMU 456%0 -> 0x000001C8
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM of the same operands -> 0x00000000
  - Latency is still 33 edges in every case.
- Rd=0 MUL 3x4 -> Done pulses, RegWrite=0. A second Start 5 cycles into an op is ignored (exactly one Done). Back-to-back Start in the Done cycle is accepted.
- Reset asserted 10 cycles into a DIV -> Busy/Done/RegWrite/WriteData go to 0 immediately. No Done appears afterward. A new MUL 2x3 after reset release returns 6.
